// File: rtl/viterbi_stream_decoder_if.sv
// rtl/viterbi_stream_decoder_if.sv - control, observation stream and decoded-path stream of the Viterbi decoder
interface viterbi_stream_decoder_if #(
  parameter int SW = 2,
  parameter int OW = 2,
  parameter int LW = 7
);
  logic          start;
  logic [LW-1:0] length;
  logic [OW-1:0] obs_in;
  logic          obs_valid;
  logic          obs_ready;
  logic [SW-1:0] path_out;
  logic          path_valid;
  logic          path_ready;
  logic          path_last;
  logic          busy;
  logic          done;
  logic          err_len;

  modport master (
    output start, length, obs_in, obs_valid, path_ready,
    input  obs_ready, path_out, path_valid, path_last, busy, done, err_len
  );

  modport slave (
    input  start, length, obs_in, obs_valid, path_ready,
    output obs_ready, path_out, path_valid, path_last, busy, done, err_len
  );
endinterface

// File: rtl/viterbi_stream_decoder.sv
// rtl/viterbi_stream_decoder.sv - streaming log-domain HMM Viterbi decoder with normalised saturating metrics
module viterbi_stream_decoder #(
  parameter int N  = 64,
  parameter int I  = 4,
  parameter int K  = 4,
  parameter int W  = 16,
  parameter int SW = $clog2(I),
  parameter int OW = $clog2(K),
  parameter int LW = $clog2(N + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  viterbi_stream_decoder_if.slave bus,
  input  logic [I*I*W-1:0]     logA_flat,
  input  logic [I*W-1:0]       logC_flat,
  input  logic [I*K*W-1:0]     logB_flat
);
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [W-1:0] MET_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] MET_MAX = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, FWD, SEL, BACK, OUT, FIN} state_t;
  state_t state, state_n;

  logic [LW-1:0]       len_q, t, o;
  logic [SW-1:0]       s, sel_s;
  logic                err_len_q, err_done;
  logic signed [W-1:0] delta [I];
  logic signed [W-1:0] dn [I];
  logic signed [W-1:0] dnorm [I];
  logic [SW-1:0]       psi_row [I];
  logic [SW-1:0]       psi_mem [N][I];
  logic [SW-1:0]       pathmem [N];
  logic                accept, t_last, len_bad, out_fire;
  logic [AW-1:0]       t_idx, o_idx;

  function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    logic [W:0] r;
    r = {a[W-1], a} + {b[W-1], b};
    if (r[W] != r[W-1]) return r[W] ? MET_MIN : MET_MAX;
    return r[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] sat_sub(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    logic [W:0] r;
    r = {a[W-1], a} - {b[W-1], b};
    if (r[W] != r[W-1]) return r[W] ? MET_MIN : MET_MAX;
    return r[W-1:0];
  endfunction

  assign accept   = (state == FWD) && bus.obs_valid;
  assign out_fire = (state == OUT) && bus.path_ready;
  assign t_last   = (t == len_q - LW'(1));
  assign len_bad  = (bus.length == '0) || (bus.length > LW'(N));
  assign t_idx    = t[AW-1:0];
  assign o_idx    = o[AW-1:0];

  // One trellis step: strict '>' keeps the lowest index on ties.
  always_comb begin
    logic signed [W-1:0] best, cand, mx;
    for (int j = 0; j < I; j++) begin
      best       = sat_add(delta[0], logA_flat[j*W +: W]);
      psi_row[j] = '0;
      for (int x = 1; x < I; x++) begin
        cand = sat_add(delta[x], logA_flat[(x*I+j)*W +: W]);
        if (cand > best) begin
          best       = cand;
          psi_row[j] = SW'(x);
        end
      end
      if (t == '0) dn[j] = sat_add(logC_flat[j*W +: W], logB_flat[(j*K+int'(bus.obs_in))*W +: W]);
      else         dn[j] = sat_add(best, logB_flat[(j*K+int'(bus.obs_in))*W +: W]);
    end
    mx = dn[0];
    for (int j = 1; j < I; j++) if (dn[j] > mx) mx = dn[j];
    for (int j = 0; j < I; j++) dnorm[j] = sat_sub(dn[j], mx);
  end

  always_comb begin
    logic signed [W-1:0] mx;
    sel_s = '0;
    mx    = delta[0];
    for (int x = 1; x < I; x++) begin
      if (delta[x] > mx) begin
        mx    = delta[x];
        sel_s = SW'(x);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n        = state;
    bus.obs_ready  = 1'b0;
    bus.path_valid = 1'b0;
    bus.path_last  = 1'b0;
    bus.path_out   = '0;
    bus.busy       = (state != IDLE);
    bus.done       = err_done;
    bus.err_len    = err_len_q;
    case (state)
      IDLE: if (bus.start && !err_done && !len_bad) state_n = FWD;
      FWD: begin
        bus.obs_ready = 1'b1;
        if (accept && t_last) state_n = SEL;
      end
      SEL:  state_n = (len_q > LW'(1)) ? BACK : OUT;
      BACK: if (t == LW'(1)) state_n = OUT;
      OUT: begin
        bus.path_valid = 1'b1;
        bus.path_out   = pathmem[o_idx];
        bus.path_last  = (o == len_q - LW'(1));
        if (out_fire && bus.path_last) state_n = FIN;
      end
      FIN: begin
        bus.done = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      t         <= '0;
      o         <= '0;
      s         <= '0;
      err_len_q <= 1'b0;
      err_done  <= 1'b0;
      for (int i = 0; i < I; i++) delta[i] <= '0;
    end else begin
      err_done <= 1'b0;
      case (state)
        IDLE: if (bus.start && !err_done) begin
          len_q     <= bus.length;
          t         <= '0;
          err_len_q <= len_bad;
          err_done  <= len_bad;
        end
        FWD: if (accept) begin
          for (int i = 0; i < I; i++) delta[i] <= dnorm[i];
          if (!t_last) t <= t + LW'(1);
        end
        SEL: begin
          s <= sel_s;
          o <= '0;
        end
        BACK: begin
          s <= psi_mem[t_idx][s];
          t <= t - LW'(1);
        end
        OUT: if (out_fire) o <= o + LW'(1);
        default: ;
      endcase
    end
  end

  // Survivor and path storage carry no reset; they are always written before being read.
  always_ff @(posedge clk) begin
    if (accept && t != '0)
      for (int j = 0; j < I; j++) psi_mem[t_idx][j] <= psi_row[j];
    if (state == SEL)  pathmem[len_q[AW-1:0] - AW'(1)] <= sel_s;
    if (state == BACK) pathmem[t_idx - AW'(1)] <= psi_mem[t_idx][s];
  end
endmodule

// File: doc/viterbi_stream_decoder.md
Name: viterbi_stream_decoder

Overview:
- Streaming HMM Viterbi decoder; next generation of the team's fixed-length log-domain decoder.
- Accepts one observation per cycle over a valid/ready handshake and keeps metrics bounded with per-step max-normalisation and saturating adds.
- Backtracks one step per cycle from a psi (survivor) memory, then streams the decoded state sequence out over a second valid/ready port.
- Sits between the observation front-end and the downstream path consumer; HMM tables are static flat buses from the parameter register file.

Parameters:
N, 64, max sequence length (psi memory depth)
I, 4, number of hidden states (>=2)
K, 4, number of observation symbols (>=2)
W, 16, signed metric width
SW, $clog2(I), state index width (derived)
OW, $clog2(K), symbol width (derived)
LW, $clog2(N+1), length width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a sequence, sampled only in IDLE
length  in  LW  sequence length L, latched at start
obs_in  in  OW  observation symbol
obs_valid  in  1  obs_in valid
obs_ready  out  1  decoder accepts an observation this cycle
logA_flat  in  I*I*W  logA[x][j] (from x to j) at bits [(x*I+j)*W +: W]
logC_flat  in  I*W  initial log-prob of state i at [i*W +: W]
logB_flat  in  I*K*W  logB[i][k] at [(i*K+k)*W +: W]
path_out  out  SW  decoded state, time order t=0..L-1
path_valid  out  1  path_out valid
path_ready  in  1  consumer accepts path_out
path_last  out  1  marks t=L-1 beat
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of sequence
err_len  out  1  sticky length error, cleared by the next accepted start

Behaviour:
- Reset values: obs_ready=0, path_valid=0, path_last=0, path_out=0, busy=0, done=0, err_len=0, state=IDLE, all metrics 0.
- States: IDLE, FWD, SEL, BACK, OUT, FIN.
- IDLE: on start, latch L. If L==0 or L>N: set err_len, pulse done the next cycle, stay IDLE, produce no output. Otherwise clear err_len, t=0, go to FWD.
- FWD: obs_ready=1. Each accepted beat (obs_valid && obs_ready) is processed in the same cycle; throughput is 1 obs/cycle.
  - t=0: delta[i] = sat(logC[i] + logB[i][obs]).
  - t>0: cand[x] = sat(delta[x] + logA[x][j]). psi[t][j] = argmax_x cand. delta'[j] = sat(max cand + logB[j][obs]).
  - Normalisation: after each step, subtract max_i delta'[i] from every entry, so the best metric is 0 and all others are <=0. The subtraction saturates to -2^(W-1).
  - sat() is signed saturating addition to W bits computed at W+1 bits: clamp to [-2^(W-1), 2^(W-1)-1].
  - Ties in any argmax resolve to the lowest index.
  - After the beat where t==L-1, deassert obs_ready and go to SEL. Extra obs_valid beats are not consumed.
- SEL (1 cycle): s = argmax delta with lowest-index ties; pathmem[L-1] = s. Go to BACK if L>1, else OUT.
- BACK: one step per cycle for t=L-1 down to 1: s = psi[t][s]; pathmem[t-1] = s. Takes L-1 cycles, then go to OUT.
- OUT: beat index o from 0 to L-1.
  - path_out = pathmem[o], path_valid=1, path_last = (o==L-1).
  - Output is held stable while path_ready=0; o advances on each accepted beat.
  - After the last beat is accepted, go to FIN.
- FIN: done=1 for one cycle, then IDLE.
- start is ignored outside IDLE. A start in the same cycle as done is ignored.
- Latency from the last observation accepted to the first path_valid: 1 (SEL) + (L-1) (BACK) + 1 cycles.
- Reset mid-operation: all state is abandoned, outputs return to reset values, and no partial path is emitted.
- The psi memory (N x I x SW) and pathmem (N x SW) are plain registers/RAM and are not reset.

Test Plan:
- I=2,K=2 weather HMM: logC={-1,-2}, logA={{-1,-3},{-3,-1}}, logB={{-1,-4},{-4,-1}}, L=4, obs=0,0,1,1 -> path 0,0,1,1; path_last on beat 4; done one cycle after last handshake.
- L=1, obs=1, same tables -> SEL then OUT directly; a single beat path_out=1 with path_last=1; zero BACK cycles.
- length=0 and length=N+1 -> err_len=1, done pulse, path_valid never asserted; next valid start clears err_len.
- Saturation: logB entries = -2^(W-1)+1 for state 0, L=N=64, random obs -> no metric wraps; state-1 metric stays 0 after normalisation; matches the golden model with saturation.
- Backpressure: random obs_valid gaps and path_ready held low 5 cycles mid-stream -> output identical to the golden model; path_out stable while stalled; obs_ready low outside FWD.
- Reset asserted during BACK with L=10 -> busy/path_valid drop asynchronously; a fresh start then decodes correctly; all-equal tables give path all zeros (tie rule).
